// File: rtl/mux_n_scan.sv
// N-channel, W-bit registered multiplexer with manual select and auto-scan modes.
// Scan mode steps an internal channel counter with a programmable dwell per channel.
module mux_n_scan #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SELW  = $clog2(N),
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  i,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    y,
    output logic [SELW-1:0] y_sel,
    output logic            valid,
    output logic            wrap,
    output logic            err
);

    localparam int DCW  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int NSEL = 2 ** SELW;

    logic [W-1:0]    w_chan [NSEL];
    logic            w_sel_ok;
    logic            w_entry;
    logic [SELW-1:0] w_step_ch;
    logic [DCW-1:0]  w_step_dc;
    logic            w_dwell_done;
    logic            w_last_ch;

    logic [W-1:0]    r_y;
    logic [SELW-1:0] r_y_sel;
    logic            r_valid;
    logic            r_wrap;
    logic            r_err;
    logic [SELW-1:0] r_ch;
    logic [DCW-1:0]  r_dc;
    logic            r_mode_q;
    logic            r_wrap_pend;

    // Unused select codes (non power-of-two N) read as zero.
    for (genvar k = 0; k < NSEL; k++) begin : g_chan
        if (k < N) begin : g_live
            assign w_chan[k] = i[k*W +: W];
        end else begin : g_pad
            assign w_chan[k] = '0;
        end
    end

    // The entry cycle counts as the first dwell cycle of the loaded channel.
    always_comb begin
        w_sel_ok     = 32'(sel) < N;
        w_entry      = mode && !r_mode_q;
        w_step_ch    = w_entry ? (w_sel_ok ? sel : '0) : r_ch;
        w_step_dc    = w_entry ? '0 : r_dc;
        w_dwell_done = 32'(w_step_dc) == DWELL - 1;
        w_last_ch    = 32'(w_step_ch) == N - 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y         <= '0;
            r_y_sel     <= '0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_err       <= 1'b0;
            r_ch        <= '0;
            r_dc        <= '0;
            r_mode_q    <= 1'b0;
            r_wrap_pend <= 1'b0;
        end else begin
            r_mode_q <= mode;
            r_valid  <= 1'b0;
            r_wrap   <= 1'b0;
            r_err    <= 1'b0;
            if (en) begin
                if (!mode) begin
                    r_y_sel <= sel;
                    if (w_sel_ok) begin
                        r_y     <= w_chan[sel];
                        r_valid <= 1'b1;
                    end else begin
                        r_y   <= '0;
                        r_err <= 1'b1;
                    end
                end else begin
                    r_y         <= w_chan[w_step_ch];
                    r_y_sel     <= w_step_ch;
                    r_valid     <= 1'b1;
                    // Wrap is flagged alongside the first output of channel 0.
                    r_wrap      <= !w_entry && r_wrap_pend;
                    r_wrap_pend <= 1'b0;
                    if (w_dwell_done) begin
                        r_dc <= '0;
                        if (w_last_ch) begin
                            r_ch        <= '0;
                            r_wrap_pend <= 1'b1;
                        end else begin
                            r_ch <= w_step_ch + 1'b1;
                        end
                    end else begin
                        r_dc <= w_step_dc + 1'b1;
                    end
                end
            end
        end
    end

    assign y     = r_y;
    assign y_sel = r_y_sel;
    assign valid = r_valid;
    assign wrap  = r_wrap;
    assign err   = r_err;

endmodule

// File: tb/tb_mux_n_scan.sv
// Scoreboard bench for mux_n_scan: N=4/DWELL=2 and N=3/DWELL=1 instances,
// directed stimulus pushes expected outputs, per-instance monitors pop and compare.
module tb_mux_n_scan;

    typedef struct {
        logic [7:0] y;
        logic [3:0] sel;
        logic       v;
        logic       w;
        logic       e;
        string      nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] i4    = '0;
    logic [1:0]  sel4  = '0;
    logic        mode4 = 1'b0;
    logic        en4   = 1'b0;
    logic [7:0]  y4;
    logic [1:0]  ysel4;
    logic        valid4, wrap4, err4;

    logic [23:0] i3    = '0;
    logic [1:0]  sel3  = '0;
    logic        mode3 = 1'b0;
    logic        en3   = 1'b0;
    logic [7:0]  y3;
    logic [1:0]  ysel3;
    logic        valid3, wrap3, err3;

    exp_t q4[$];
    exp_t q3[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mux_n_scan #(.N(4), .W(8), .DWELL(2)) u_dut4 (
        .clk(clk), .rst(rst), .i(i4), .sel(sel4), .mode(mode4), .en(en4),
        .y(y4), .y_sel(ysel4), .valid(valid4), .wrap(wrap4), .err(err4)
    );

    mux_n_scan #(.N(3), .W(8), .DWELL(1)) u_dut3 (
        .clk(clk), .rst(rst), .i(i3), .sel(sel3), .mode(mode3), .en(en3),
        .y(y3), .y_sel(ysel3), .valid(valid3), .wrap(wrap3), .err(err3)
    );

    task automatic check(input string nm, input logic [7:0] y, input logic [3:0] s,
                         input logic v, input logic w, input logic e, input exp_t ex);
        n_checks++;
        if ({y, s, v, w, e} !== {ex.y, ex.sel, ex.v, ex.w, ex.e}) begin
            n_fail++;
            $display("FAIL %s: got y=%h sel=%0d valid=%b wrap=%b err=%b, expected y=%h sel=%0d valid=%b wrap=%b err=%b",
                     nm, y, s, v, w, e, ex.y, ex.sel, ex.v, ex.w, ex.e);
        end
    endtask

    initial begin : mon4
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (q4.size() > 0) begin
                ex = q4.pop_front();
                check(ex.nm, y4, {2'b00, ysel4}, valid4, wrap4, err4, ex);
            end
        end
    end

    initial begin : mon3
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (q3.size() > 0) begin
                ex = q3.pop_front();
                check(ex.nm, y3, {2'b00, ysel3}, valid3, wrap3, err3, ex);
            end
        end
    end

    task automatic step4(input logic [1:0] s, input logic m, input logic e_, input logic [31:0] iv,
                         input logic [7:0] ey, input logic [1:0] es, input logic ev,
                         input logic ew, input logic ee, input string nm);
        exp_t ex;
        @(negedge clk);
        sel4 = s; mode4 = m; en4 = e_; i4 = iv;
        ex.y = ey; ex.sel = {2'b00, es}; ex.v = ev; ex.w = ew; ex.e = ee; ex.nm = nm;
        q4.push_back(ex);
    endtask

    task automatic step3(input logic [1:0] s, input logic m, input logic e_, input logic [23:0] iv,
                         input logic [7:0] ey, input logic [1:0] es, input logic ev,
                         input logic ew, input logic ee, input string nm);
        exp_t ex;
        @(negedge clk);
        sel3 = s; mode3 = m; en3 = e_; i3 = iv;
        ex.y = ey; ex.sel = {2'b00, es}; ex.v = ev; ex.w = ew; ex.e = ee; ex.nm = nm;
        q3.push_back(ex);
    endtask

    localparam logic [31:0] I4  = 32'h44332211;
    localparam logic [31:0] IA  = 32'h443322AA;
    localparam logic [31:0] I5A = 32'h4433225A;
    localparam logic [23:0] I3  = 24'hCCBBAA;

    initial begin : stim
        exp_t zero;
        zero.y = '0; zero.sel = '0; zero.v = 1'b0; zero.w = 1'b0; zero.e = 1'b0; zero.nm = "rst";

        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset while y holds AA
        step4(2'd0, 1'b0, 1'b1, IA, 8'hAA, 2'd0, 1'b1, 1'b0, 1'b0, "pre_rst");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", y4, {2'b00, ysel4}, valid4, wrap4, err4, zero);
        en4 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 4; s++)
            step4(2'(s), 1'b0, 1'b1, I4, 8'((s + 1) * 17), 2'(s), 1'b1, 1'b0, 1'b0, "manual_sweep");

        for (int k = 0; k < 9; k++)
            step4(2'd0, 1'b1, 1'b1, I4, 8'(((k / 2) % 4 + 1) * 17), 2'((k / 2) % 4),
                  1'b1, (k == 8), 1'b0, "scan_dwell2");

        step4(2'd0, 1'b1, 1'b1, I4, 8'h11, 2'd0, 1'b1, 1'b0, 1'b0, "gate_pre0");
        step4(2'd0, 1'b1, 1'b1, I4, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0, "gate_pre1");
        for (int k = 0; k < 3; k++)
            step4(2'd0, 1'b1, 1'b0, I4, 8'h22, 2'd1, 1'b0, 1'b0, 1'b0, "gate_hold");
        step4(2'd0, 1'b1, 1'b1, I4, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0, "gate_resume");
        step4(2'd0, 1'b1, 1'b1, I4, 8'h33, 2'd2, 1'b1, 1'b0, 1'b0, "gate_next");

        step4(2'd0, 1'b0, 1'b1, I4, 8'h11, 2'd0, 1'b1, 1'b0, 1'b0, "mode_exit");
        step4(2'd2, 1'b1, 1'b1, I4, 8'h33, 2'd2, 1'b1, 1'b0, 1'b0, "entry_load");
        step4(2'd2, 1'b1, 1'b1, I4, 8'h33, 2'd2, 1'b1, 1'b0, 1'b0, "entry_dwell");
        step4(2'd2, 1'b1, 1'b1, I4, 8'h44, 2'd3, 1'b1, 1'b0, 1'b0, "entry_ch3a");
        step4(2'd2, 1'b1, 1'b1, I4, 8'h44, 2'd3, 1'b1, 1'b0, 1'b0, "entry_ch3b");
        step4(2'd2, 1'b1, 1'b1, I4, 8'h11, 2'd0, 1'b1, 1'b1, 1'b0, "entry_wrap");
        step4(2'd2, 1'b1, 1'b1, I5A, 8'h5A, 2'd0, 1'b1, 1'b0, 1'b0, "live_input");
        @(negedge clk);
        en4 = 1'b0;

        step3(2'd3, 1'b0, 1'b1, I3, 8'h00, 2'd3, 1'b0, 1'b0, 1'b1, "sel_err");
        step3(2'd1, 1'b0, 1'b1, I3, 8'hBB, 2'd1, 1'b1, 1'b0, 1'b0, "after_err");
        step3(2'd2, 1'b0, 1'b1, I3, 8'hCC, 2'd2, 1'b1, 1'b0, 1'b0, "manual_top");
        step3(2'd3, 1'b1, 1'b1, I3, 8'hAA, 2'd0, 1'b1, 1'b0, 1'b0, "d1_entry_bad_sel");
        step3(2'd3, 1'b1, 1'b1, I3, 8'hBB, 2'd1, 1'b1, 1'b0, 1'b0, "d1_ch1");
        step3(2'd3, 1'b1, 1'b1, I3, 8'hCC, 2'd2, 1'b1, 1'b0, 1'b0, "d1_ch2");
        step3(2'd3, 1'b1, 1'b1, I3, 8'hAA, 2'd0, 1'b1, 1'b1, 1'b0, "d1_wrap");
        step3(2'd3, 1'b1, 1'b1, I3, 8'hBB, 2'd1, 1'b1, 1'b0, 1'b0, "d1_after_wrap");
        @(negedge clk);
        en3 = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (q4.size() != 0 || q3.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0", q4.size(), q3.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_n_scan.md
Name: mux_n_scan

Overview:
Parametrised N-channel, W-bit registered multiplexer. It succeeds the fixed 4:1 combinational mux. It adds two modes: manual select, and an auto-scan mode in which an internal channel counter steps through the inputs with a programmable dwell time. Outputs are registered and carry the channel index, a valid flag, a scan-wrap pulse and a select-error flag. It sits between parallel data sources and a single serial consumer, such as a monitor, ADC-style sampler or debug tap.

Parameters:
N, 4, number of input channels (2..16).
W, 8, data width per channel in bits (>=1).
SELW, $clog2(N), select/index width (derived; do not override).
DWELL, 4, clock cycles spent on each channel in scan mode (>=1).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
i  input  N*W  packed channel data; channel k = i[k*W +: W]
sel  input  SELW  manual channel select
mode  input  1  0 = manual, 1 = auto-scan
en  input  1  advance/capture enable
y  output  W  registered selected data
y_sel  output  SELW  channel index that produced y
valid  output  1  y/y_sel updated this cycle
wrap  output  1  one-cycle pulse when scan returns from channel N-1 to 0
err  output  1  one-cycle pulse when a manual sel >= N is captured

Behaviour:
- Reset (async assert, sync release): y=0, y_sel=0, valid=0, wrap=0, err=0, channel counter ch=0, dwell counter dc=0, mode register mode_q=0.
- All outputs are registered; latency is 1 cycle from input sample to output.
- en=0:
  - ch and dc freeze; y and y_sel hold.
  - valid=0, wrap=0, err=0.
- Manual mode (mode=1'b0, en=1):
  - If sel<N: y<=i[sel], y_sel<=sel, valid<=1, err<=0.
  - If sel>=N (only possible when N is not a power of 2): y<=0, y_sel<=sel, valid<=0, err<=1.
  - ch and dc are not advanced.
- Scan mode (mode=1, en=1):
  - Each cycle: y<=i[ch], y_sel<=ch, valid<=1.
  - dc increments every cycle.
  - When dc==DWELL-1: dc<=0 and ch advances.
    - If ch==N-1: ch<=0 and wrap<=1 for the cycle in which ch changes to 0.
    - Otherwise ch<=ch+1.
  - DWELL=1: ch advances every enabled cycle.
- Mode entry 0->1 (detected as mode && !mode_q):
  - On that cycle ch<=(sel<N ? sel : 0) and dc<=0.
  - The output for that cycle is i[that loaded ch].
  - Scan continues from that channel.
- Mode exit 1->0: takes effect on the same edge (manual path). ch and dc retain their values but are unused.
- mode_q tracks mode every clock, regardless of en.
- Simultaneous dwell expiry and mode entry: the entry load wins.
- i may change at any time. Scan output reflects i as sampled at each edge, not as held at channel entry.
- Reset mid-scan: all state returns to reset values immediately. Scan restarts at channel 0 only when mode=1 is re-entered or held after release; a held mode=1 at release is treated as entry with ch=sel.

Test Plan:
- Reset: assert rst mid-cycle with y=8'hAA -> y, y_sel, valid, wrap, err all 0 without waiting for a clk edge.
- Manual sweep, N=4, W=8: i={8'h44,8'h33,8'h22,8'h11}, en=1, sel=0,1,2,3 on successive cycles -> one cycle later y=11,22,33,44, y_sel=0..3, valid=1.
- Scan, DWELL=2, same i, sel=0:
  - Raise mode -> y sequence 11,11,22,22,33,33,44,44,11.
  - wrap=1 only on the cycle y returns to 11.
- Enable gating: in scan with DWELL=2, drop en for 3 cycles after the first 22 -> valid=0 and y held at 22. On re-enable, the second 22 appears, then 33.
- Mode entry load: sel=2, mode 0->1 -> first scan y=33, y_sel=2. Then 33, 44, 44, 11 with a wrap pulse.
- Error, N=3 (SELW=2), manual sel=3 -> err=1 for one cycle, valid=0, y=0. Then sel=1 -> y=i[1], err=0.
